ccp_mac_fmt: RTL and testbench

CCP_MAC_FMT -- requirements
Module: ccp_mac_fmt

---
 rtl/ccp_pkg.sv | 17 +
 rtl/ccp_lane_pack.sv | 33 +++
 rtl/ccp_mac_fmt.sv | 172 +++++++++++++++++
 tb/tb_ccp_mac_fmt.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ccp_pkg.sv
// Shared types and constants for the ChaCha20-Poly1305 MAC input formatter.
package ccp_pkg;

    // Poly1305 consumes 16-byte blocks.
    localparam int CCP_POLY_BLK_BYTES = 16;
    // Each length field in the final block is a 64-bit little-endian word.
    localparam int CCP_LEN_BLK_W      = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AD,
        ST_CT,
        ST_LEN,
        ST_DONE
    } ccp_state_e;

endpackage

// File: rtl/ccp_lane_pack.sv
// Inserts the valid low lanes of one input beat into the 16-byte block buffer
// at the current fill offset. Legal beat widths divide 16 and every phase
// flushes on its last beat, so a beat never straddles two blocks.
module ccp_lane_pack
    import ccp_pkg::*;
#(
    parameter int P_IN_BYTES = 4
) (
    input  logic [CCP_POLY_BLK_BYTES*8-1:0] blk_in,
    input  logic [4:0]                      fill,
    input  logic [4:0]                      nbytes,
    input  logic [8*P_IN_BYTES-1:0]         data,
    output logic [CCP_POLY_BLK_BYTES*8-1:0] blk_out,
    output logic [4:0]                      fill_out,
    output logic                            full
);

    // Copy lane k of the beat into buffer byte fill+k for every valid lane.
    always_comb begin
        blk_out = blk_in;
        for (int k = 0; k < P_IN_BYTES; k++) begin
            int idx;
            idx = int'(fill) + k;
            if ((k < int'(nbytes)) && (idx < CCP_POLY_BLK_BYTES)) begin
                blk_out[idx*8 +: 8] = data[k*8 +: 8];
            end
        end
    end

    assign fill_out = fill + nbytes;
    assign full     = (fill_out == 5'(CCP_POLY_BLK_BYTES));

endmodule

// File: rtl/ccp_mac_fmt.sv
// Formats AD || pad16 || CT || pad16 || le64(len_ad) || le64(len_ct) into
// 128-bit Poly1305 blocks from a stream of P_IN_BYTES-wide input beats.
// Optional feature macro: CCP_MAC_FMT_ERR_EN adds a sticky protocol-error
// output o_err. P_LEN_W must be at least 5 (byte counts feed a 5-bit take).
module ccp_mac_fmt
    import ccp_pkg::*;
#(
    parameter int P_IN_BYTES = 4,
    parameter int P_LEN_W    = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_start,
    input  logic [P_LEN_W-1:0]      i_len_ad,
    input  logic [P_LEN_W-1:0]      i_len_ct,
    input  logic                    i_valid,
    input  logic [8*P_IN_BYTES-1:0] i_data,
    output logic                    o_ready,
    output logic                    o_valid,
    output logic [127:0]            o_blk,
    output logic                    o_last,
    input  logic                    i_ready,
    output logic                    o_busy,
    output logic                    o_done
`ifdef CCP_MAC_FMT_ERR_EN
   ,output logic                    o_err
`endif
);

    ccp_state_e state, state_nxt;

    logic [P_LEN_W-1:0] len_ad, len_ct;
    logic [P_LEN_W-1:0] cnt, cnt_nxt;
    logic [127:0]       blk_buf, pack_blk, blk_q;
    logic [4:0]         fill, pack_fill, take;
    logic               pack_full;
    logic               vld_q, last_q;
    logic               in_phase, accept, phase_end, emit, hs, start_ok;
    logic [CCP_LEN_BLK_W-1:0] len_ad64, len_ct64;

    assign in_phase  = (state == ST_AD) || (state == ST_CT);
    // A beat is only taken when no block is waiting on the downstream side.
    assign accept    = in_phase && !vld_q && i_valid;
    assign start_ok  = (state == ST_IDLE) && i_start;
    assign hs        = vld_q && i_ready;
    assign cnt_nxt   = cnt - P_LEN_W'(take);
    assign phase_end = (cnt_nxt == '0);
    assign emit      = accept && (pack_full || phase_end);
    assign len_ad64  = CCP_LEN_BLK_W'(len_ad);
    assign len_ct64  = CCP_LEN_BLK_W'(len_ct);

    // Bytes consumed by this beat: a full beat, or whatever is left in the phase.
    always_comb begin
        take = 5'(P_IN_BYTES);
        if (cnt < P_LEN_W'(P_IN_BYTES)) take = cnt[4:0];
    end

    ccp_lane_pack #(.P_IN_BYTES(P_IN_BYTES)) u_pack (
        .blk_in   (blk_buf),
        .fill     (fill),
        .nbytes   (take),
        .data     (i_data),
        .blk_out  (pack_blk),
        .fill_out (pack_fill),
        .full     (pack_full)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state: skip empty phases at start and at the AD/CT boundary.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_len_ad != '0)      state_nxt = ST_AD;
                    else if (i_len_ct != '0) state_nxt = ST_CT;
                    else                     state_nxt = ST_LEN;
                end
            end
            ST_AD: begin
                if (accept && phase_end) state_nxt = (len_ct != '0) ? ST_CT : ST_LEN;
            end
            ST_CT: begin
                if (accept && phase_end) state_nxt = ST_LEN;
            end
            ST_LEN: begin
                // Only the length block (last_q) ends the message; a CT block
                // still draining in LEN just frees the output register.
                if (hs && last_q) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        o_ready = in_phase && !vld_q;
        o_busy  = (state != ST_IDLE);
        o_done  = (state == ST_DONE);
    end

    // Datapath: length capture, byte counter, pack buffer and output block.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            len_ad  <= '0;
            len_ct  <= '0;
            cnt     <= '0;
            blk_buf <= '0;
            fill    <= '0;
            blk_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            if (start_ok) begin
                len_ad  <= i_len_ad;
                len_ct  <= i_len_ct;
                cnt     <= (i_len_ad != '0) ? i_len_ad : i_len_ct;
                blk_buf <= '0;
                fill    <= '0;
            end
            if (hs) begin
                vld_q  <= 1'b0;
                last_q <= 1'b0;
            end
            if (accept) begin
                if (emit) begin
                    blk_q   <= pack_blk;
                    vld_q   <= 1'b1;
                    last_q  <= 1'b0;
                    blk_buf <= '0;
                    fill    <= '0;
                end else begin
                    blk_buf <= pack_blk;
                    fill    <= pack_fill;
                end
                // End of AD reloads the counter with the CT length.
                cnt <= (phase_end && (state == ST_AD)) ? len_ct : cnt_nxt;
            end
            // Once any trailing CT block has drained, present the length block.
            if ((state == ST_LEN) && !vld_q) begin
                blk_q  <= {len_ct64, len_ad64};
                vld_q  <= 1'b1;
                last_q <= 1'b1;
            end
        end
    end

    assign o_valid = vld_q;
    assign o_blk   = blk_q;
    assign o_last  = last_q;

`ifdef CCP_MAC_FMT_ERR_EN
    logic err_q;

    // Sticky protocol error: start while busy or a beat offered outside a phase.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)                                           err_q <= 1'b0;
        else if (start_ok)                                     err_q <= 1'b0;
        else if ((i_start && (state != ST_IDLE)) ||
                 (i_valid && !in_phase))                       err_q <= 1'b1;
    end

    assign o_err = err_q;
`endif

endmodule

// File: tb/tb_ccp_mac_fmt.sv
// Directed bench for ccp_mac_fmt: one 4-byte-beat and one 16-byte-beat instance.
module tb_ccp_mac_fmt;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] start, valid, iready, ordy, ovalid, last, busy, done;
    logic [1:0][63:0]  len_ad, len_ct;
    logic [1:0][127:0] data, blk;
`ifdef CCP_MAC_FMT_ERR_EN
    logic [1:0] err;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [127:0] got_q[$];
    logic         gl_q[$];
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    ccp_mac_fmt #(.P_IN_BYTES(4), .P_LEN_W(64)) u4 (
        .i_clk(clk), .i_rstn(rst_n), .i_start(start[0]),
        .i_len_ad(len_ad[0]), .i_len_ct(len_ct[0]),
        .i_valid(valid[0]), .i_data(data[0][31:0]), .o_ready(ordy[0]),
        .o_valid(ovalid[0]), .o_blk(blk[0]), .o_last(last[0]),
        .i_ready(iready[0]), .o_busy(busy[0]), .o_done(done[0])
`ifdef CCP_MAC_FMT_ERR_EN
       ,.o_err(err[0])
`endif
    );

    ccp_mac_fmt #(.P_IN_BYTES(16), .P_LEN_W(64)) u16 (
        .i_clk(clk), .i_rstn(rst_n), .i_start(start[1]),
        .i_len_ad(len_ad[1]), .i_len_ct(len_ct[1]),
        .i_valid(valid[1]), .i_data(data[1]), .o_ready(ordy[1]),
        .o_valid(ovalid[1]), .o_blk(blk[1]), .o_last(last[1]),
        .i_ready(iready[1]), .o_busy(busy[1]), .o_done(done[1])
`ifdef CCP_MAC_FMT_ERR_EN
       ,.o_err(err[1])
`endif
    );

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] ad_b(input int i);
        return 8'(i * 3 + 1);
    endfunction

    function automatic logic [7:0] ct_b(input int i);
        return 8'(i * 7 + 5);
    endfunction

    // Reference block sequence built straight from the byte definitions.
    task automatic build_exp(input int lad, input int lct);
        logic [127:0] b;
        exp_q.delete();
        for (int i = 0; i < lad; i += 16) begin
            b = '0;
            for (int j = 0; j < 16; j++) if (i + j < lad) b[8*j +: 8] = ad_b(i + j);
            exp_q.push_back(b);
        end
        for (int i = 0; i < lct; i += 16) begin
            b = '0;
            for (int j = 0; j < 16; j++) if (i + j < lct) b[8*j +: 8] = ct_b(i + j);
            exp_q.push_back(b);
        end
        exp_q.push_back({64'(lct), 64'(lad)});
    endtask

    task automatic chk_out_zero(input int d);
        chk("rst_valid", 128'(ovalid[d]), 128'd0);
        chk("rst_ready", 128'(ordy[d]),   128'd0);
        chk("rst_last",  128'(last[d]),   128'd0);
        chk("rst_busy",  128'(busy[d]),   128'd0);
        chk("rst_done",  128'(done[d]),   128'd0);
        chk("rst_blk",   blk[d],          128'd0);
    endtask

    // Runs one message on instance d. stall toggles i_ready; abort_n > 0 pulses
    // reset once that many blocks were accepted; inj pulses i_start during CT.
    task automatic run_msg(input int d, input int lad, input int lct,
                           input bit stall, input int abort_n, input bit inj);
        int np, pos, cyc, ndone, rem, nb, hs_cyc, done_cyc;
        bit prev_stall, injected;
        logic [127:0] prev;
        np = (d != 0) ? 16 : 4;
        got_q.delete();
        gl_q.delete();
        build_exp(lad, lct);
        @(negedge clk);
        start[d]  = 1'b1;
        len_ad[d] = 64'(lad);
        len_ct[d] = 64'(lct);
        @(negedge clk);
        start[d]  = 1'b0;
        len_ad[d] = '1;
        len_ct[d] = '1;
`ifdef CCP_MAC_FMT_ERR_EN
        chk("err_clr", 128'(err[d]), 128'd0);
`endif
        pos = 0; cyc = 0; ndone = 0; hs_cyc = -100; done_cyc = 0;
        prev_stall = 1'b0; injected = 1'b0; prev = '0;
        while (ndone == 0 && cyc < 2000) begin
            if (done[d]) begin
                ndone++;
                done_cyc = cyc;
            end
            if (prev_stall) begin
                chk("stall_valid", 128'(ovalid[d]), 128'd1);
                chk("stall_blk",   blk[d],          prev);
            end
            start[d] = 1'b0;
            if (ndone == 0) begin
                iready[d] = stall ? cyc[0] : 1'b1;
                if (ovalid[d] && iready[d]) begin
                    got_q.push_back(blk[d]);
                    gl_q.push_back(last[d]);
                    if (last[d]) hs_cyc = cyc;
                end
                prev_stall = ovalid[d] && !iready[d];
                prev       = blk[d];
                valid[d] = 1'b0;
                data[d]  = {16{8'hEE}};
                if (ordy[d] && pos < lad + lct) begin
                    if (pos < lad) begin
                        rem = lad - pos;
                        nb  = (rem < np) ? rem : np;
                        for (int k = 0; k < nb; k++) data[d][8*k +: 8] = ad_b(pos + k);
                    end else begin
                        rem = lad + lct - pos;
                        nb  = (rem < np) ? rem : np;
                        for (int k = 0; k < nb; k++) data[d][8*k +: 8] = ct_b(pos - lad + k);
                    end
                    valid[d] = 1'b1;
                    pos += nb;
                end
                if (inj && !injected && pos > lad + 4 && pos < lad + lct) begin
                    start[d]  = 1'b1;
                    len_ad[d] = 64'd3;
                    len_ct[d] = 64'd3;
                    injected  = 1'b1;
                end
                @(negedge clk);
                cyc++;
                if (abort_n > 0 && got_q.size() == abort_n) begin
                    #2 rst_n = 1'b0;
                    #1 chk_out_zero(d);
                    for (int i = 0; i < abort_n; i++) chk("abort_blk", got_q[i], exp_q[i]);
                    @(negedge clk);
                    chk("abort_quiet", 128'(ovalid[d]), 128'd0);
                    rst_n = 1'b1; valid[d] = 1'b0; start[d] = 1'b0;
                    return;
                end
            end
        end
        valid[d] = 1'b0;
        chk("done_seen", 128'(ndone), 128'd1);
        chk("done_lat", 128'(done_cyc - hs_cyc), 128'd1);
        chk("nblk", 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk("blk", (i < got_q.size()) ? got_q[i] : 128'hx, exp_q[i]);
            chk("last", (i < gl_q.size()) ? 128'(gl_q[i]) : 128'hx, 128'(i == exp_q.size() - 1));
        end
        @(negedge clk);
        chk("busy_end", 128'(busy[d]), 128'd0);
        chk("done_1cyc", 128'(done[d]), 128'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = '0; valid = '0; iready = '1;
        len_ad = '0; len_ct = '0; data = '0;
        #12;
        chk_out_zero(0);
        chk_out_zero(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 128'(ordy[0]), 128'd0);

        // RFC 8439 2.8.2 shape: 12 AD bytes, 114 CT bytes, 4-byte beats.
        run_msg(0, 12, 114, 1'b0, 0, 1'b0);
        chk("rfc_nblk",  128'(got_q.size()), 128'd10);
        chk("rfc_ad_lo", 128'(got_q[0][31:0]),   128'h0A070401);
        chk("rfc_ad_pad", 128'(got_q[0][127:96]), 128'd0);
        chk("rfc_ct_tail", 128'(got_q[8][15:0]),  128'h1C15);
        chk("rfc_ct_pad", 128'(got_q[8][127:16]), 128'd0);
        chk("rfc_len", got_q[9], 128'h0000000000000072_000000000000000C);

        // Empty message: only the zero length block.
        run_msg(0, 0, 0, 1'b0, 0, 1'b0);
        chk("empty_blk", got_q[0], 128'd0);

        // 16-byte beats with a stalling consumer.
        run_msg(1, 16, 32, 1'b1, 0, 1'b0);
        chk("stall_len", got_q[3], 128'h0000000000000020_0000000000000010);

        // Partial beats in both phases with garbage upper lanes.
        run_msg(1, 5, 3, 1'b0, 0, 1'b0);
        chk("short_ad", got_q[0], 128'h0D0A070401);

        // Beats offered in IDLE are ignored.
        @(negedge clk);
        valid[0] = 1'b1; data[0] = '1;
        repeat (3) @(negedge clk);
        chk("idle_noready", 128'(ordy[0]), 128'd0);
        chk("idle_nobusy",  128'(busy[0]), 128'd0);
`ifdef CCP_MAC_FMT_ERR_EN
        chk("err_idle_valid", 128'(err[0]), 128'd1);
`endif
        valid[0] = 1'b0;
        run_msg(0, 20, 7, 1'b0, 0, 1'b0);

        // Reset after 3 of 9 blocks, then a clean rerun.
        run_msg(0, 32, 96, 1'b0, 3, 1'b0);
        run_msg(0, 32, 96, 1'b0, 0, 1'b0);

        // Stray start during CT must not disturb the message.
        run_msg(0, 16, 40, 1'b0, 0, 1'b1);
`ifdef CCP_MAC_FMT_ERR_EN
        chk("err_sticky", 128'(err[0]), 128'd1);
        run_msg(0, 4, 4, 1'b0, 0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
